// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index type plus hazard-unit state and defaults.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    HALT   = 2'd2
  } hzstate_t;

  localparam int HZ_WAIT_MAX_DEF = 64;
  localparam int HZ_CNT_W_DEF    = 8;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Load-use detector: a load in EX whose destination feeds an operand of the ID instruction.
module hazard_loaduse_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dren,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);

  // $zero is never a real dependency, even when a load targets it.
  assign load_use = ex_dren && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline with dmem-wait FSM, halt and watchdog.
// Define HAZARD_PERF_EN to add the stall/flush/load-use performance counters.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WAIT_MAX = HZ_WAIT_MAX_DEF,
  parameter int CNT_W    = HZ_CNT_W_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_wsel,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_redirect,
  input  logic        id_jump,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halted,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] loaduse_count
`endif
);

  hzstate_t         state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_inc;
  logic             mem_req;
  logic             load_use;

  assign mem_req  = mem_dREN | mem_dWEN;
  assign wait_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

  hazard_loaduse_detect u_loaduse (
    .ex_dren  (ex_dREN),
    .ex_wsel  (ex_wsel),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (load_use)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      // Only a cycle spent waiting in DSTALL that stays in DSTALL counts as a wait.
      if (state == DSTALL && state_next == DSTALL) begin
        wait_cnt <= wait_inc;
        if (wait_inc == CNT_W'(WAIT_MAX))
          mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;

    if (RST) begin
      state_next  = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (wb_halt) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      state_next = HALT;
    end else if (mem_req && !dhit) begin
      // EX is frozen, so a pending redirect or load-use re-presents after the wait.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_next  = DSTALL;
    end else begin
      state_next = RUN;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic perf_active, perf_flush, perf_loaduse;

  // IF/ID flush with a redirect or jump present can only come from those priorities;
  // an ID/EX flush without a redirect can only be the load-use bubble.
  assign perf_active  = (state != HALT);
  assign perf_flush   = perf_active && ifid_flush && (ex_redirect || id_jump);
  assign perf_loaduse = perf_active && idex_flush && !ex_redirect;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      loaduse_count <= '0;
    end else begin
      if (perf_active && !pc_en)
        stall_cycles <= stall_cycles + 32'd1;
      if (perf_flush)
        flush_count <= flush_count + 32'd1;
      if (perf_loaduse)
        loaduse_count <= loaduse_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (built with WAIT_MAX=4).
module tb_hazard_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       ex_redirect, id_jump, wb_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       halted, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count, loaduse_count;
`endif

  int errors = 0;
  int checks = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, 4 flushes, halted, mem_timeout}
  logic [10:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, mem_timeout};

  localparam logic [10:0] O_RUN    = 11'b11111_0000_00;
  localparam logic [10:0] O_RESET  = 11'b00000_1111_00;
  localparam logic [10:0] O_LU     = 11'b00111_0100_00;
  localparam logic [10:0] O_DWAIT  = 11'b00001_0001_00;
  localparam logic [10:0] O_REDIR  = 11'b11111_1100_00;
  localparam logic [10:0] O_JUMP   = 11'b11111_1000_00;
  localparam logic [10:0] O_NOIHIT = 11'b01111_1000_00;
  localparam logic [10:0] O_HALTGO = 11'b00000_0000_00;
  localparam logic [10:0] O_HALT   = 11'b00000_0000_10;
  localparam logic [10:0] O_DWAIT_TO = 11'b00001_0001_01;
  localparam logic [10:0] O_RUN_TO   = 11'b11111_0000_01;

  hazard_control_unit #(.WAIT_MAX(4), .CNT_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_dREN    (mem_dREN),
    .mem_dWEN    (mem_dWEN),
    .ex_dREN     (ex_dREN),
    .ex_wsel     (ex_wsel),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_redirect (ex_redirect),
    .id_jump     (id_jump),
    .wb_halt     (wb_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .halted      (halted),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .loaduse_count (loaduse_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_dREN = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    ex_redirect = 1'b0; id_jump = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_RESET);
    end else $display("check reset_outs: %b", outs);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL run_after_reset: got %b expected %b", outs, O_RUN);
    end else $display("check run_after_reset: %b", outs);
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    idle_inputs(); ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd3; id_rt = 5'd5;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL loaduse_rt: got %b expected %b", outs, O_LU);
    end else $display("check loaduse_rt: %b", outs);
    @(negedge CLK);
    ex_dREN = 1'b0;
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL loaduse_release: got %b expected %b", outs, O_RUN);
    end else $display("check loaduse_release: %b", outs);
    @(negedge CLK);
    idle_inputs(); ex_dREN = 1'b1; ex_wsel = 5'd7; id_rs = 5'd7; id_rt = 5'd2;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL loaduse_rs: got %b expected %b", outs, O_LU);
    end else $display("check loaduse_rs: %b", outs);
    @(negedge CLK);
    idle_inputs(); ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd9;
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL loaduse_reg0: got %b expected %b", outs, O_RUN);
    end else $display("check loaduse_reg0: %b", outs);
  endtask

  task automatic test_dmem_wait();
    @(negedge CLK);
    idle_inputs(); mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_DWAIT) begin
        errors++; $display("FAIL dwait_cycle%0d: got %b expected %b", i, outs, O_DWAIT);
      end else $display("check dwait_cycle%0d: %b", i, outs);
      @(negedge CLK);
    end
    dhit = 1'b1;
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL dwait_hit: got %b expected %b", outs, O_RUN);
    end else $display("check dwait_hit: %b", outs);
    @(negedge CLK);
    idle_inputs(); ihit = 1'b0;
    #1;
    checks++;
    if (outs !== O_NOIHIT) begin
      errors++; $display("FAIL dwait_after_noihit: got %b expected %b", outs, O_NOIHIT);
    end else $display("check dwait_after_noihit: %b", outs);
  endtask

  task automatic test_simultaneous();
    @(negedge CLK);
    idle_inputs(); mem_dWEN = 1'b1; ex_redirect = 1'b1;
    #1;
    checks++;
    if (outs !== O_DWAIT) begin
      errors++; $display("FAIL simul_stall: got %b expected %b", outs, O_DWAIT);
    end else $display("check simul_stall: %b", outs);
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      errors++; $display("FAIL simul_release: got %b expected %b", outs, O_REDIR);
    end else $display("check simul_release: %b", outs);
  endtask

  task automatic test_priority();
    @(negedge CLK);
    idle_inputs(); ex_redirect = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4;
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      errors++; $display("FAIL redirect_over_lu: got %b expected %b", outs, O_REDIR);
    end else $display("check redirect_over_lu: %b", outs);
    @(negedge CLK);
    idle_inputs(); id_jump = 1'b1; ihit = 1'b0;
    #1;
    checks++;
    if (outs !== O_JUMP) begin
      errors++; $display("FAIL jump_noihit: got %b expected %b", outs, O_JUMP);
    end else $display("check jump_noihit: %b", outs);
    @(negedge CLK);
    idle_inputs(); id_jump = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd12; id_rt = 5'd12;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_over_jump: got %b expected %b", outs, O_LU);
    end else $display("check lu_over_jump: %b", outs);
    @(negedge CLK);
    idle_inputs(); ihit = 1'b0;
    #1;
    checks++;
    if (outs !== O_NOIHIT) begin
      errors++; $display("FAIL noihit: got %b expected %b", outs, O_NOIHIT);
    end else $display("check noihit: %b", outs);
  endtask

  task automatic test_timeout();
    logic [10:0] exp;
    @(negedge CLK);
    idle_inputs(); mem_dREN = 1'b1;
    // Request cycle in RUN, then DSTALL cycles; the flag appears after the 4th DSTALL cycle.
    for (int i = 0; i < 7; i++) begin
      exp = (i >= 5) ? O_DWAIT_TO : O_DWAIT;
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL timeout_cycle%0d: got %b expected %b", i, outs, exp);
      end else $display("check timeout_cycle%0d: %b", i, outs);
      @(negedge CLK);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL timeout_async_rst: got %b expected %b", outs, O_RESET);
    end else $display("check timeout_async_rst: %b", outs);
    #2 RST = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL timeout_cleared: got %b expected %b", outs, O_RUN);
    end else $display("check timeout_cleared: %b", outs);
    @(negedge CLK);
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL state_run_after_rst: got %b expected %b", outs, O_RUN);
    end else $display("check state_run_after_rst: %b", outs);
  endtask

  task automatic test_sticky_timeout();
    @(negedge CLK);
    idle_inputs(); mem_dREN = 1'b1;
    repeat (6) @(negedge CLK);
    dhit = 1'b1;
    #1;
    checks++;
    if (outs !== O_RUN_TO) begin
      errors++; $display("FAIL timeout_release: got %b expected %b", outs, O_RUN_TO);
    end else $display("check timeout_release: %b", outs);
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if (outs !== O_RUN_TO) begin
      errors++; $display("FAIL timeout_sticky: got %b expected %b", outs, O_RUN_TO);
    end else $display("check timeout_sticky: %b", outs);
    #1 RST = 1'b1;
    #2 RST = 1'b0;
  endtask

  task automatic test_halt();
    @(negedge CLK);
    idle_inputs(); wb_halt = 1'b1; ex_redirect = 1'b1;
    #1;
    checks++;
    if (outs !== O_HALTGO) begin
      errors++; $display("FAIL halt_enter: got %b expected %b", outs, O_HALTGO);
    end else $display("check halt_enter: %b", outs);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      idle_inputs();
      ex_redirect = (i == 1); mem_dREN = (i == 2); id_jump = (i == 3); ihit = (i != 0);
      #1;
      checks++;
      if (outs !== O_HALT) begin
        errors++; $display("FAIL halt_hold%0d: got %b expected %b", i, outs, O_HALT);
      end else $display("check halt_hold%0d: %b", i, outs);
    end
    @(negedge CLK);
    idle_inputs();
    #1 RST = 1'b1;
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL halt_rst: got %b expected %b", outs, O_RESET);
    end else $display("check halt_rst: %b", outs);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (outs !== O_RUN) begin
      errors++; $display("FAIL halt_exit: got %b expected %b", outs, O_RUN);
    end else $display("check halt_exit: %b", outs);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_simultaneous();
    test_priority();
    test_timeout();
    test_sticky_timeout();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
